// File: rtl/fetch_branch_sequencer_pkg.sv
// rtl/fetch_branch_sequencer_pkg.sv - shared opcodes, field slices and enums for the fetch/branch sequencer
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int OFF_W   = 9;

    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_RET  = 4'hF;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int COND_HI = 11;
    localparam int COND_LO = 9;
    localparam int OFF_HI  = 8;
    localparam int OFF_LO  = 0;

    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_Z  = 3'd1,
        COND_NZ = 3'd2,
        COND_N  = 3'd3,
        COND_NN = 3'd4,
        COND_C  = 3'd5,
        COND_NC = 3'd6,
        COND_NV = 3'd7
    } cond_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Flags arrive packed as {C,N,Z}.
    function automatic logic cond_met(input cond_t c, input logic [2:0] flags);
        logic fz, fn, fc;
        {fc, fn, fz} = flags;
        case (c)
            COND_AL: return 1'b1;
            COND_Z:  return fz;
            COND_NZ: return !fz;
            COND_N:  return fn;
            COND_NN: return !fn;
            COND_C:  return fc;
            COND_NC: return !fc;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_branch_sequencer_if.sv
// rtl/fetch_branch_sequencer_if.sv - instruction memory req/valid fetch channel
interface fetch_branch_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              InstrReq;
    logic [ADDR_W-1:0] InstrAddr;
    logic              InstrValid;
    logic [15:0]       InstrData;

    modport master (output InstrReq, output InstrAddr, input InstrValid, input InstrData);
    modport slave  (input InstrReq, input InstrAddr, output InstrValid, output InstrData);
endinterface

// File: rtl/fetch_branch_sequencer_return_address_stack.sv
// rtl/fetch_branch_sequencer_return_address_stack.sv - LIFO of return addresses for CALL/RET
module return_address_stack #(
    parameter int STACK_DEPTH = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Push,
    input  logic                         Pop,
    input  logic [ADDR_W-1:0]            PushData,
    output logic [ADDR_W-1:0]            PopData,
    output logic                         Full,
    output logic                         Empty,
    output logic [$clog2(STACK_DEPTH):0] Level
);
    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]  top_idx;

    assign top_idx = PTR_W'(ptr_q - 1'b1);
    assign Full    = (ptr_q == (PTR_W + 1)'(STACK_DEPTH));
    assign Empty   = (ptr_q == '0);
    assign Level   = ptr_q;
    assign PopData = mem_q[top_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (Push && !Full) begin
            ptr_d = ptr_q + 1'b1;
        end else if (Pop && !Empty) begin
            ptr_d = ptr_q - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage is deliberately left uncleared by reset; only the pointer matters.
    always_ff @(posedge Clock) begin
        if (!Reset && Push && !Full) begin
            mem_q[ptr_q[PTR_W-1:0]] <= PushData;
        end
    end

endmodule

// File: rtl/fetch_branch_sequencer.sv
// rtl/fetch_branch_sequencer.sv - fetches instruction words, resolves control flow and steers the PC
module fetch_branch_sequencer #(
    parameter int STACK_DEPTH = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [ADDR_W-1:0]            PcValue,
    output logic [ADDR_W-1:0]            LoadValue,
    output logic                         LoadEnable,
    output logic [8:0]                   Offset,
    output logic                         OffsetEnable,
    fetch_branch_sequencer_if.master     imem,
    input  logic [2:0]                   Flags,
    input  logic [ADDR_W-1:0]            JumpTarget,
    output logic                         IssueValid,
    output logic [15:0]                  IssueInstr,
    output logic [$clog2(STACK_DEPTH):0] StackLevel,
    output logic                         Fault
);
    import fetch_pkg::*;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic               push, pop, stk_full, stk_empty;
    logic [ADDR_W-1:0]  push_data, pop_data;
    logic               instr_req;
    logic [ADDR_W-1:0]  instr_addr;

    logic [3:0]         opcode;
    cond_t              cond;
    logic [OFF_W-1:0]   off;

    assign opcode    = ir_q[OPC_HI:OPC_LO];
    assign cond      = cond_t'(ir_q[COND_HI:COND_LO]);
    assign off       = ir_q[OFF_HI:OFF_LO];
    assign push_data = PcValue + ADDR_W'(1);

    assign imem.InstrReq  = instr_req;
    assign imem.InstrAddr = instr_addr;

    return_address_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_ras (
        .Clock    (Clock),
        .Reset    (Reset),
        .Push     (push),
        .Pop      (pop),
        .PushData (push_data),
        .PopData  (pop_data),
        .Full     (stk_full),
        .Empty    (stk_empty),
        .Level    (StackLevel)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // The PC free-runs, so "hold" means reloading it with its own value.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        instr_req    = 1'b0;
        instr_addr   = '0;
        LoadEnable   = 1'b0;
        LoadValue    = '0;
        OffsetEnable = 1'b0;
        Offset       = '0;
        IssueValid   = 1'b0;
        IssueInstr   = '0;
        Fault        = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;

        case (state_q)
            FETCH: begin
                instr_req  = 1'b1;
                instr_addr = PcValue;
                LoadEnable = 1'b1;
                LoadValue  = PcValue;
                if (imem.InstrValid) begin
                    ir_d    = imem.InstrData;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_BR: begin
                        if (cond_met(cond, Flags)) begin
                            OffsetEnable = 1'b1;
                            Offset       = off;
                        end
                    end
                    OP_JMP: begin
                        LoadEnable = 1'b1;
                        LoadValue  = JumpTarget;
                    end
                    OP_CALL: begin
                        if (!stk_full) begin
                            push         = 1'b1;
                            OffsetEnable = 1'b1;
                            Offset       = off;
                        end else begin
                            LoadEnable = 1'b1;
                            LoadValue  = PcValue;
                            state_d    = FAULT;
                        end
                    end
                    OP_RET: begin
                        if (!stk_empty) begin
                            pop        = 1'b1;
                            LoadEnable = 1'b1;
                            LoadValue  = pop_data;
                        end else begin
                            LoadEnable = 1'b1;
                            LoadValue  = PcValue;
                            state_d    = FAULT;
                        end
                    end
                    default: begin
                        IssueValid = 1'b1;
                        IssueInstr = ir_q;
                    end
                endcase
            end
            FAULT: begin
                Fault      = 1'b1;
                LoadEnable = 1'b1;
                LoadValue  = PcValue;
            end
            default: state_d = FETCH;
        endcase

        if (Reset) begin
            state_d      = FETCH;
            ir_d         = '0;
            instr_req    = 1'b0;
            instr_addr   = '0;
            LoadEnable   = 1'b0;
            LoadValue    = '0;
            OffsetEnable = 1'b0;
            Offset       = '0;
            IssueValid   = 1'b0;
            IssueInstr   = '0;
            Fault        = 1'b0;
            push         = 1'b0;
            pop          = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_branch_sequencer.sv
// tb/tb_fetch_branch_sequencer.sv - directed bench with an instruction-level reference model
module tb_fetch_branch_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] PcValue, JumpTarget, LoadValue, IssueInstr;
    logic        LoadEnable, OffsetEnable, IssueValid, Fault;
    logic [8:0]  Offset;
    logic [2:0]  Flags;
    logic [3:0]  StackLevel;

    always #5 Clock = ~Clock;

    fetch_branch_sequencer_if #(.ADDR_W(16)) imem ();

    fetch_branch_sequencer #(.STACK_DEPTH(8), .ADDR_W(16)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .PcValue      (PcValue),
        .LoadValue    (LoadValue),
        .LoadEnable   (LoadEnable),
        .Offset       (Offset),
        .OffsetEnable (OffsetEnable),
        .imem         (imem.master),
        .Flags        (Flags),
        .JumpTarget   (JumpTarget),
        .IssueValid   (IssueValid),
        .IssueInstr   (IssueInstr),
        .StackLevel   (StackLevel),
        .Fault        (Fault)
    );

    int n_chk = 0;
    int n_err = 0;
    int issue_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: 0 = waiting for a word, 1 = acting on m_word, 2 = faulted.
    int          m_phase = 0;
    int          m_next;
    bit          m_known = 1'b0;
    logic [15:0] m_word;
    logic [15:0] m_stack[$];
    logic        e_req, e_le, e_oe, e_iv, e_f, taken, do_push, do_pop;
    logic [15:0] e_lv;
    logic [8:0]  e_off;
    logic        fz, fn, fc;

    always @(negedge Clock) begin
        if (IssueValid === 1'b1) issue_cnt++;
        if (Reset === 1'b1) begin
            chk("rst_ctl", 32'({imem.InstrReq, IssueValid, LoadEnable, OffsetEnable, Fault}), 32'd0);
            chk("rst_val", 32'({LoadValue, Offset}), 32'd0);
            m_phase = 0;
            m_stack.delete();
            m_known = 1'b1;
        end else if (m_known) begin
            e_req = 0; e_le = 0; e_oe = 0; e_iv = 0; e_f = 0;
            e_lv = 0; e_off = 0; do_push = 0; do_pop = 0;
            m_next = m_phase;
            {fc, fn, fz} = Flags;
            if (m_phase == 0) begin
                e_req = 1; e_le = 1; e_lv = PcValue;
                if (imem.InstrValid === 1'b1) begin
                    m_next = 1;
                    m_word = imem.InstrData;
                end
            end else if (m_phase == 1) begin
                m_next = 0;
                case (m_word[15:12])
                    4'hC: begin
                        case (m_word[11:9])
                            3'd0: taken = 1;
                            3'd1: taken = fz;
                            3'd2: taken = ~fz;
                            3'd3: taken = fn;
                            3'd4: taken = ~fn;
                            3'd5: taken = fc;
                            3'd6: taken = ~fc;
                            default: taken = 0;
                        endcase
                        if (taken) begin e_oe = 1; e_off = m_word[8:0]; end
                    end
                    4'hD: begin e_le = 1; e_lv = JumpTarget; end
                    4'hE: begin
                        if (m_stack.size() < 8) begin
                            e_oe = 1; e_off = m_word[8:0]; do_push = 1;
                        end else begin
                            e_le = 1; e_lv = PcValue; m_next = 2;
                        end
                    end
                    4'hF: begin
                        if (m_stack.size() > 0) begin
                            e_le = 1; e_lv = m_stack[$]; do_pop = 1;
                        end else begin
                            e_le = 1; e_lv = PcValue; m_next = 2;
                        end
                    end
                    default: e_iv = 1;
                endcase
            end else begin
                e_f = 1; e_le = 1; e_lv = PcValue;
            end
            chk("instr_req", 32'(imem.InstrReq), 32'(e_req));
            if (e_req) chk("instr_addr", 32'(imem.InstrAddr), 32'(PcValue));
            chk("load", 32'({LoadEnable, LoadValue}), 32'({e_le, e_lv}));
            chk("offset", 32'({OffsetEnable, Offset}), 32'({e_oe, e_off}));
            chk("issue", 32'(IssueValid), 32'(e_iv));
            if (e_iv) chk("issue_instr", 32'(IssueInstr), 32'(m_word));
            chk("fault", 32'(Fault), 32'(e_f));
            chk("level", 32'(StackLevel), 32'(m_stack.size()));
            if (do_push) m_stack.push_back(PcValue + 16'd1);
            if (do_pop) void'(m_stack.pop_back());
            m_phase = m_next;
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic half();
        @(negedge Clock);
        #1;
    endtask

    // Leaves the bench at the start of the execute cycle of word w.
    task automatic fetch_word(input logic [15:0] w, input int waits);
        imem.InstrValid = 1'b0;
        repeat (waits) cyc();
        imem.InstrValid = 1'b1;
        imem.InstrData  = w;
        cyc();
        imem.InstrValid = 1'b0;
        imem.InstrData  = 16'h0000;
    endtask

    logic [2:0]  flag_pat [4] = '{3'b000, 3'b111, 3'b010, 3'b101};
    logic [15:0] w;

    initial begin
        Reset = 1'b1; PcValue = 16'h0000; JumpTarget = 16'h0000; Flags = 3'b000;
        imem.InstrValid = 1'b0; imem.InstrData = 16'h0000;
        cyc(); cyc();

        // Plain instruction with zero wait cycles
        Reset = 1'b0;
        imem.InstrValid = 1'b1; imem.InstrData = 16'h1234;
        half();
        chk("t1_fetch_hold", 32'({LoadEnable, LoadValue, imem.InstrReq}), 32'({1'b1, 16'h0000, 1'b1}));
        cyc();
        imem.InstrValid = 1'b0;
        half();
        chk("t1_issue", 32'({IssueValid, IssueInstr, LoadEnable, OffsetEnable}), 32'({1'b1, 16'h1234, 1'b0, 1'b0}));
        cyc();

        // Branch on Z, taken then not taken
        PcValue = 16'h0040; Flags = 3'b001;
        fetch_word(16'hC3F0, 0);
        half();
        chk("t2_br_taken", 32'({OffsetEnable, Offset, IssueValid}), 32'({1'b1, 9'h1F0, 1'b0}));
        cyc();
        Flags = 3'b000;
        fetch_word(16'hC3F0, 0);
        half();
        chk("t2_br_not", 32'({OffsetEnable, Offset, IssueValid, LoadEnable}), 32'd0);
        cyc();

        // Every condition code against several flag patterns
        foreach (flag_pat[p]) begin
            Flags = flag_pat[p];
            for (int c = 0; c < 8; c++) begin
                w = {4'hC, 3'(c), 9'h005};
                fetch_word(w, 0);
                cyc();
            end
        end

        // CALL then RET
        PcValue = 16'h0100;
        fetch_word(16'hE005, 0);
        half();
        chk("t3_call_off", 32'({OffsetEnable, Offset}), 32'({1'b1, 9'h005}));
        cyc();
        PcValue = 16'h0105;
        half();
        chk("t3_level1", 32'(StackLevel), 32'd1);
        cyc();
        fetch_word(16'hF000, 0);
        half();
        chk("t3_ret", 32'({LoadEnable, LoadValue}), 32'({1'b1, 16'h0101}));
        cyc();
        half();
        chk("t3_level0", 32'(StackLevel), 32'd0);
        cyc();

        // Return address wraps at the top of the address space
        PcValue = 16'hFFFF;
        fetch_word(16'hE1FF, 0);
        cyc();
        PcValue = 16'h0010;
        fetch_word(16'hF000, 0);
        half();
        chk("t3_wrap_ret", 32'({LoadEnable, LoadValue}), 32'({1'b1, 16'h0000}));
        cyc();

        // Absolute jump
        JumpTarget = 16'h1357;
        fetch_word(16'hD000, 1);
        half();
        chk("t3_jmp", 32'({LoadEnable, LoadValue, OffsetEnable}), 32'({1'b1, 16'h1357, 1'b0}));
        cyc();

        // Slow memory: five wait cycles, one issue
        PcValue = 16'h0300;
        issue_cnt = 0;
        fetch_word(16'h2222, 5);
        cyc();
        cyc();
        chk("t5_issue_once", 32'(issue_cnt), 32'd1);

        // Overflow on the ninth CALL
        Reset = 1'b1; cyc(); Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            PcValue = 16'h0200 + 16'(i);
            fetch_word(16'hE001, 0);
            cyc();
        end
        half();
        chk("t4_level8", 32'(StackLevel), 32'd8);
        cyc();
        PcValue = 16'h0208;
        fetch_word(16'hE001, 0);
        half();
        chk("t4_ovf_hold", 32'({LoadEnable, LoadValue, OffsetEnable, Fault}), 32'({1'b1, 16'h0208, 1'b0, 1'b0}));
        cyc();
        half();
        chk("t4_ovf_fault", 32'(Fault), 32'd1);
        cyc();
        imem.InstrValid = 1'b1; imem.InstrData = 16'h1111;
        repeat (20) cyc();
        Reset = 1'b1; imem.InstrValid = 1'b0;
        half();
        chk("t4_rst_clears", 32'(Fault), 32'd0);
        cyc();
        Reset = 1'b0;
        PcValue = 16'h0500;
        fetch_word(16'hF000, 0);
        cyc();
        half();
        chk("t4_underflow", 32'(Fault), 32'd1);
        cyc();
        Reset = 1'b1; cyc(); Reset = 1'b0;

        // Reset landing in the execute cycle of a JMP
        PcValue = 16'h0400;
        fetch_word(16'hE002, 0);
        cyc();
        JumpTarget = 16'hBEEF;
        fetch_word(16'hD000, 0);
        Reset = 1'b1;
        half();
        chk("t6_rst_exec", 32'({LoadEnable, LoadValue}), 32'd0);
        cyc();
        Reset = 1'b0;
        half();
        chk("t6_after_rst", 32'({StackLevel, imem.InstrReq}), 32'({4'd0, 1'b1}));
        cyc();
        fetch_word(16'h3333, 0);
        half();
        chk("t6_issue", 32'({IssueValid, IssueInstr}), 32'({1'b1, 16'h3333}));
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
